// File: rtl/stack_sequencer.sv
// Sequences an external 8-bit up/down counter as a descending stack pointer and
// runs the matching stack-memory write (push) or read (pop) with a ready handshake.
module stack_sequencer #(
  parameter logic [7:0] STACK_BASE  = 8'h00,
  parameter logic [7:0] STACK_LIMIT = 8'hF0
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_load_req,
  input  logic [7:0] i_load_value,
  input  logic       i_push_req,
  input  logic [7:0] i_push_data,
  input  logic       i_pop_req,
  output logic [7:0] o_pop_data,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_overflow,
  output logic       o_underflow,
  input  logic [7:0] i_cnt_value,
  output logic       o_cnt_decrement,
  output logic       o_cnt_setvalue,
  output logic [7:0] o_cnt_valuein,
  output logic [7:0] o_mem_addr,
  output logic [7:0] o_mem_wdata,
  output logic       o_mem_we,
  output logic       o_mem_re,
  input  logic [7:0] i_mem_rdata,
  input  logic       i_mem_ready
);

  // state    | meaning
  // S_INIT   | write STACK_BASE into the counter after reset
  // S_IDLE   | sample requests (load > pop > push)
  // S_PUSH_WR| write latched byte at SP until mem_ready
  // S_POP_RD | read at SP until mem_ready, then SP+1
  // S_DONE   | one-cycle completion
  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_PUSH_WR, S_POP_RD, S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_push_data;
  logic [7:0] r_pop_data;
  logic       r_done;
  logic       r_overflow;
  logic       r_underflow;
  logic       w_set_ovf;
  logic       w_set_udf;
  logic       w_latch_push;
  logic       w_capture_pop;
  logic       w_refusal_pulse;

  // A refused request is still held during its pulse cycle; it must not be re-sampled.
  assign w_refusal_pulse = r_overflow | r_underflow;

  always_comb begin
    w_next          = r_state;
    o_busy          = 1'b1;
    o_cnt_setvalue  = 1'b1;
    o_cnt_decrement = 1'b0;
    o_cnt_valuein   = i_cnt_value;
    o_mem_addr      = 8'h00;
    o_mem_wdata     = 8'h00;
    o_mem_we        = 1'b0;
    o_mem_re        = 1'b0;
    w_set_ovf       = 1'b0;
    w_set_udf       = 1'b0;
    w_latch_push    = 1'b0;
    w_capture_pop   = 1'b0;
    case (r_state)
      S_INIT: begin
        o_cnt_valuein = STACK_BASE;
        w_next        = S_IDLE;
      end
      S_IDLE: begin
        o_busy = 1'b0;
        if (!w_refusal_pulse) begin
          if (i_load_req) begin
            o_cnt_valuein = i_load_value;
            w_next        = S_DONE;
          end else if (i_pop_req) begin
            if (i_cnt_value == STACK_BASE) w_set_udf = 1'b1;
            else                           w_next    = S_POP_RD;
          end else if (i_push_req) begin
            if (i_cnt_value == STACK_LIMIT) begin
              w_set_ovf = 1'b1;
            end else begin
              o_cnt_setvalue  = 1'b0;
              o_cnt_decrement = 1'b1;
              w_latch_push    = 1'b1;
              w_next          = S_PUSH_WR;
            end
          end
        end
      end
      S_PUSH_WR: begin
        o_mem_addr  = i_cnt_value;
        o_mem_wdata = r_push_data;
        o_mem_we    = 1'b1;
        if (i_mem_ready) w_next = S_DONE;
      end
      S_POP_RD: begin
        o_mem_addr = i_cnt_value;
        o_mem_re   = 1'b1;
        if (i_mem_ready) begin
          // counter counts up when neither setvalue nor decrement is asserted
          o_cnt_setvalue = 1'b0;
          w_capture_pop  = 1'b1;
          w_next         = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_INIT;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_INIT;
      r_push_data <= 8'h00;
      r_pop_data  <= 8'h00;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_done      <= (w_next == S_DONE);
      r_overflow  <= w_set_ovf;
      r_underflow <= w_set_udf;
      if (w_latch_push)  r_push_data <= i_push_data;
      if (w_capture_pop) r_pop_data  <= i_mem_rdata;
    end
  end

  assign o_pop_data  = r_pop_data;
  assign o_done      = r_done;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: models the up/down counter and a ready-handshake memory,
// checks directed cases and random request streams against an abstract stack model.
module tb_stack_sequencer;
  localparam logic [7:0] BASE  = 8'h00;
  localparam logic [7:0] LIMIT = 8'hF0;
  localparam int K_NONE = 0, K_DONE = 1, K_OVF = 2, K_UDF = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load_req = 1'b0, push_req = 1'b0, pop_req = 1'b0;
  logic [7:0] load_value = 8'h00, push_data = 8'h00;
  logic [7:0] pop_data;
  logic       busy, done, overflow, underflow;
  logic [7:0] cnt_value = 8'h5A;
  logic       cnt_decrement, cnt_setvalue;
  logic [7:0] cnt_valuein;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, mem_re, mem_ready;

  int checks = 0, failures = 0;
  int mem_delay = 0;
  int wait_cnt = 0;
  int we_total = 0, re_total = 0, wr_total = 0, rd_total = 0;
  logic [7:0] last_wr_addr = 0, last_wr_data = 0, last_rd_addr = 0;
  logic [7:0] mem_arr [256];
  logic [7:0] ref_mem [256];
  logic [7:0] sp_ref;
  logic [7:0] pop_ref;

  stack_sequencer #(.STACK_BASE(BASE), .STACK_LIMIT(LIMIT)) dut (
    .i_clock(clock), .i_reset(reset),
    .i_load_req(load_req), .i_load_value(load_value),
    .i_push_req(push_req), .i_push_data(push_data), .i_pop_req(pop_req),
    .o_pop_data(pop_data), .o_busy(busy), .o_done(done),
    .o_overflow(overflow), .o_underflow(underflow),
    .i_cnt_value(cnt_value), .o_cnt_decrement(cnt_decrement),
    .o_cnt_setvalue(cnt_setvalue), .o_cnt_valuein(cnt_valuein),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_we(mem_we), .o_mem_re(mem_re),
    .i_mem_rdata(mem_rdata), .i_mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  // External counter: loads when setvalue, otherwise counts down or up every clock.
  always @(posedge clock)
    cnt_value <= cnt_setvalue ? cnt_valuein : (cnt_decrement ? cnt_value - 8'd1 : cnt_value + 8'd1);

  // Memory responder: ready after mem_delay waiting cycles; random ready noise when idle.
  always @(negedge clock) begin
    if (mem_we || mem_re) begin
      mem_ready = (wait_cnt >= mem_delay);
      mem_rdata = mem_arr[mem_addr];
      wait_cnt  = wait_cnt + 1;
    end else begin
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = 8'($urandom);
      wait_cnt  = 0;
    end
  end

  always @(posedge clock) begin
    if (mem_we) we_total = we_total + 1;
    if (mem_re) re_total = re_total + 1;
    if (mem_we && mem_ready) begin
      mem_arr[mem_addr] = mem_wdata;
      wr_total = wr_total + 1;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
    end
    if (mem_re && mem_ready) begin
      rd_total = rd_total + 1;
      last_rd_addr = mem_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue requests, hold them until a pulse, then check the result against the model.
  task automatic run_op(input string tag, input bit ld, input bit pp, input bit ps,
                        input logic [7:0] lv, input logic [7:0] pd, input int dly);
    int exp_kind, got_kind, we0, re0, wr0, rd0;
    int exp_acc;
    logic [7:0] exp_addr;
    exp_acc = 0; exp_addr = 8'h00;
    if (ld) begin
      exp_kind = K_DONE; sp_ref = lv;
    end else if (pp) begin
      if (sp_ref == BASE) exp_kind = K_UDF;
      else begin
        exp_kind = K_DONE; exp_acc = 1; exp_addr = sp_ref;
        pop_ref = ref_mem[sp_ref]; sp_ref = sp_ref + 8'd1;
      end
    end else begin
      if (sp_ref == LIMIT) exp_kind = K_OVF;
      else begin
        exp_kind = K_DONE; exp_acc = 1;
        sp_ref = sp_ref - 8'd1; exp_addr = sp_ref; ref_mem[sp_ref] = pd;
      end
    end
    we0 = we_total; re0 = re_total; wr0 = wr_total; rd0 = rd_total;
    mem_delay = dly;
    load_req = ld; pop_req = pp; push_req = ps; load_value = lv; push_data = pd;
    got_kind = K_NONE;
    for (int c = 0; c < 300; c++) begin
      @(negedge clock);
      if (done || overflow || underflow) begin
        got_kind = done ? K_DONE : (overflow ? K_OVF : K_UDF);
        break;
      end
    end
    load_req = 1'b0; pop_req = 1'b0; push_req = 1'b0;
    chk({tag, ".kind"}, got_kind, exp_kind);
    chk({tag, ".pop_data"}, pop_data, pop_ref);
    @(negedge clock);
    chk({tag, ".sp"}, cnt_value, sp_ref);
    chk({tag, ".pulse_once"}, {done, overflow, underflow, busy}, 4'b0000);
    if (!ld && !pp) begin
      chk({tag, ".wr_count"}, wr_total - wr0, exp_acc);
      chk({tag, ".we_cycles"}, we_total - we0, exp_acc ? dly + 1 : 0);
      if (exp_acc != 0) chk({tag, ".wr_addr_data"}, {last_wr_addr, last_wr_data}, {exp_addr, pd});
    end else begin
      chk({tag, ".wr_count"}, wr_total - wr0, 0);
    end
    chk({tag, ".rd_count"}, rd_total - rd0, (pp && !ld) ? exp_acc : 0);
    if (pp && !ld) begin
      chk({tag, ".re_cycles"}, re_total - re0, exp_acc ? dly + 1 : 0);
      if (exp_acc != 0) chk({tag, ".rd_addr"}, last_rd_addr, exp_addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    sp_ref = BASE; pop_ref = 8'h00;

    // reset and INIT
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst.busy_init", busy, 1'b1);
    chk("rst.init_ctl", {cnt_setvalue, cnt_decrement, cnt_valuein}, {1'b1, 1'b0, BASE});
    chk("rst.outputs", {done, overflow, underflow, mem_we, mem_re, pop_data}, 13'h0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst.idle_busy", busy, 1'b0);
    chk("rst.sp_base", cnt_value, BASE);
    chk("rst.pulses", {done, overflow, underflow}, 3'b000);
    chk("rst.hold_ctl", {cnt_setvalue, cnt_decrement, cnt_valuein}, {1'b1, 1'b0, cnt_value});

    // directed test plan
    run_op("push_a5", 0, 0, 1, 8'h00, 8'hA5, 1);
    run_op("pop_a5", 0, 1, 0, 8'h00, 8'h00, 0);
    chk("pop_a5.value", pop_data, 8'hA5);
    run_op("pop_empty", 0, 1, 0, 8'h00, 8'h00, 0);
    run_op("load_f0", 1, 0, 0, 8'hF0, 8'h00, 0);
    run_op("push_full", 0, 0, 1, 8'h00, 8'h33, 0);
    chk("push_full.sp", cnt_value, 8'hF0);
    run_op("load_10", 1, 0, 0, 8'h10, 8'h00, 0);
    run_op("all_three", 1, 1, 1, 8'h40, 8'h77, 0);
    chk("all_three.sp", cnt_value, 8'h40);

    // reset during a stalled push
    mem_delay = 1000;
    push_req = 1'b1; push_data = 8'h3C;
    @(negedge clock);
    push_req = 1'b0;
    chk("rstpush.we", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h3F, 8'h3C});
    @(negedge clock);
    chk("rstpush.we_hold", mem_we, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk("rstpush.abandon", {mem_we, mem_re, done, busy}, 4'b0001);
    reset = 1'b0;
    @(negedge clock);
    chk("rstpush.sp", cnt_value, BASE);
    chk("rstpush.idle", {busy, done, pop_data}, 10'h0);
    sp_ref = BASE; pop_ref = 8'h00; mem_delay = 0;

    // random request streams against the stack model
    for (int n = 0; n < 80; n++) begin
      int sel;
      bit ld, pp, ps;
      logic [7:0] lv;
      sel = $urandom_range(0, 9);
      ld = (sel < 2); pp = (sel >= 2 && sel < 6); ps = (sel >= 6);
      if ($urandom_range(0, 4) == 0) begin
        pp = pp | 1'($urandom); ps = ps | 1'($urandom);
      end
      case ($urandom_range(0, 4))
        0: lv = BASE;
        1: lv = LIMIT;
        2: lv = LIMIT + 8'd1;
        3: lv = BASE + 8'd1;
        default: lv = 8'($urandom);
      endcase
      run_op("rand", ld, pp, ps, lv, 8'($urandom), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
Controller that sequences the 8-bit up/down counter as a descending stack pointer for the CPU. It accepts load, push and pop requests, drives the counter's decrement/setvalue/valuein controls, and runs the matching stack-memory write or read with a ready handshake. It flags overflow and underflow and reports completion to the core sequencer.

Parameters:
STACK_BASE, 8'h00, SP value when the stack is empty; written to the counter after reset
STACK_LIMIT, 8'hF0, SP value when the stack is full; a push at this value is refused

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
load_req  input  1  request: set SP to load_value
load_value  input  8  new SP value
push_req  input  1  request: push push_data
push_data  input  8  data to push
pop_req  input  1  request: pop into pop_data
pop_data  output  8  last popped byte
busy  output  1  request in progress; new requests are ignored
done  output  1  one-cycle completion pulse
overflow  output  1  one-cycle pulse: push refused
underflow  output  1  one-cycle pulse: pop refused
cnt_value  input  8  counter valueout (current SP)
cnt_decrement  output  1  to counter decrement
cnt_setvalue  output  1  to counter setvalue
cnt_valuein  output  8  to counter valuein
mem_addr  output  8  stack memory address
mem_wdata  output  8  stack memory write data
mem_we  output  1  write strobe, held until mem_ready
mem_re  output  1  read strobe, held until mem_ready
mem_rdata  input  8  read data, valid with mem_ready
mem_ready  input  1  memory completes the access this cycle

Behaviour:
- The counter changes on every clock unless setvalue=1. The sequencer therefore holds SP by default with cnt_setvalue=1 and cnt_valuein=cnt_value, cnt_decrement=0.
- Counter controls and mem_* are combinational from state and inputs. pop_data, the latched push data and all pulses are registered.
- States: INIT, IDLE, PUSH_WR, POP_RD, DONE.
- Reset: state moves to INIT at the edge. pop_data=0, done/overflow/underflow=0, mem_we/mem_re=0. An in-flight memory access is abandoned with no completion pulse.
- INIT: busy=1, cnt_setvalue=1, cnt_valuein=STACK_BASE. Goes to IDLE next cycle, so SP=STACK_BASE from the second cycle after reset release.
- IDLE: busy=0. Requests are sampled only here, with priority load > pop > push. Lower-priority simultaneous requests are ignored, not queued.
- Load accepted: cnt_valuein=load_value, cnt_setvalue=1 this cycle, then DONE. load_value is not range-checked.
- Push with cnt_value==STACK_LIMIT: SP held, overflow pulses next cycle, then IDLE. No DONE, no memory access.
- Push otherwise: cnt_setvalue=0, cnt_decrement=1 this cycle (SP-1 at the edge). Latch push_data, then PUSH_WR.
- PUSH_WR: mem_addr=cnt_value, mem_wdata=latched data, mem_we=1, SP held. Go to DONE on the cycle mem_ready=1.
- Pop with cnt_value==STACK_BASE: underflow pulses next cycle, SP held, then IDLE.
- Pop otherwise: SP held, go to POP_RD.
- POP_RD: mem_addr=cnt_value, mem_re=1. While mem_ready=0, SP is held. On mem_ready=1: pop_data<=mem_rdata, cnt_setvalue=0 and cnt_decrement=0 (SP+1 at the edge), then DONE.
- DONE: busy=1, done=1 for exactly one cycle, SP held, then IDLE. Requesters hold a request until done/overflow/underflow and drop it in that cycle.
- No limit on mem_ready wait; the block stays in PUSH_WR/POP_RD indefinitely.
- SP arithmetic is 8-bit modulo (via the counter). The full/empty checks exist so wrap never occurs when STACK_LIMIT < STACK_BASE mod 256 ordering is respected.
- mem_ready outside PUSH_WR/POP_RD is ignored.

Test Plan:
- Reset 2 cycles then release -> busy=1 for 1 cycle; SP=8'h00 and busy=0 afterward; all pulses 0.
- Push 8'hA5, mem_ready on 2nd PUSH_WR cycle -> SP=8'hFF, mem_we=1 for 2 cycles at addr 8'hFF/wdata 8'hA5, done 1 cycle.
- Pop after that push, mem_rdata=8'hA5 with immediate ready -> mem_re addr 8'hFF, pop_data=8'hA5, SP=8'h00, done pulse.
- Pop at SP=8'h00 -> underflow 1 cycle, no mem_re, SP unchanged. Load 8'hF0 then push -> overflow 1 cycle, SP stays 8'hF0.
- Load, pop and push asserted together at SP=8'h10, load_value=8'h40 -> SP=8'h40, no memory access, done once.
- Reset asserted during PUSH_WR with mem_ready=0 -> mem_we=0 after the edge, no done, SP re-initialised to 8'h00.
